// File: rtl/stage_ex.sv
`default_nettype none
// stage_ex -- execute stage: ALU with overflow trap, HI/LO with iterative mul/div, ex->mem bundle
// Rev 1.0
module stage_ex #(
    parameter int MUL_CYCLES     = 3,
    parameter int MEM_OPT_WIDTH  = 4,
    parameter int REGADDR_WIDTH  = 5,
    parameter int EXC_CODE_WIDTH = 5,
    parameter logic [MEM_OPT_WIDTH-1:0]  MEM_OPT_NONE = '0,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_NONE      = '0,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_OV        = EXC_CODE_WIDTH'(12)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [4:0]                id_opt,
    input  logic [31:0]               id_a,
    input  logic [31:0]               id_b,
    input  logic [4:0]                id_shamt,
    input  logic [MEM_OPT_WIDTH-1:0]  id_mem_opt,
    input  logic [31:0]               id_mem_data,
    input  logic [REGADDR_WIDTH-1:0]  id_wb_reg_addr,
    input  logic [EXC_CODE_WIDTH-1:0] id_exc_code,
    input  logic [31:0]               id_exc_epc,
    input  logic                      mem_stall,
    input  logic                      mem_clear,
    output logic                      ex_stall,
    output logic [31:0]               ex_alu_result,
    output logic [31:0]               ex_mem_addr,
    output logic [31:0]               ex_mem_data,
    output logic [31:0]               ex_exc_epc,
    output logic [31:0]               ex_exc_badvaddr,
    output logic [MEM_OPT_WIDTH-1:0]  ex_mem_opt,
    output logic [REGADDR_WIDTH-1:0]  ex_wb_reg_addr,
    output logic [EXC_CODE_WIDTH-1:0] ex_exc_code
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_SLT   = 5'd11;
    localparam logic [4:0] OP_SLTU  = 5'd12;
    localparam logic [4:0] OP_LUI   = 5'd13;
    localparam logic [4:0] OP_MULT  = 5'd14;
    localparam logic [4:0] OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV   = 5'd16;
    localparam logic [4:0] OP_DIVU  = 5'd17;
    localparam logic [4:0] OP_MFHI  = 5'd18;
    localparam logic [4:0] OP_MFLO  = 5'd19;
    localparam logic [4:0] OP_MTHI  = 5'd20;
    localparam logic [4:0] OP_MTLO  = 5'd21;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        mul_signed;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ov;
    logic        sub_ov;
    logic [31:0] alu_res;
    logic        is_mul;
    logic        is_div;
    logic        accept;
    logic        start_mul;
    logic        start_div;
    logic        div_signed;
    logic [31:0] div_a_mag;
    logic [31:0] div_b_mag;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    assign ex_stall        = (state != ST_IDLE);
    assign ex_exc_badvaddr = 32'h0;

    assign sum    = id_a + id_b;
    assign diff   = id_a - id_b;
    assign add_ov = (id_a[31] == id_b[31]) && (sum[31] != id_a[31]);
    assign sub_ov = (id_a[31] != id_b[31]) && (diff[31] != id_a[31]);

    always_comb begin
        alu_res = 32'h0;
        case (id_opt)
            OP_ADD, OP_ADDU: alu_res = sum;
            OP_SUB, OP_SUBU: alu_res = diff;
            OP_AND:          alu_res = id_a & id_b;
            OP_OR:           alu_res = id_a | id_b;
            OP_XOR:          alu_res = id_a ^ id_b;
            OP_NOR:          alu_res = ~(id_a | id_b);
            OP_SLL:          alu_res = id_b << id_shamt;
            OP_SRL:          alu_res = id_b >> id_shamt;
            OP_SRA:          alu_res = $unsigned($signed(id_b) >>> id_shamt);
            OP_SLT:          alu_res = {31'h0, $signed(id_a) < $signed(id_b)};
            OP_SLTU:         alu_res = {31'h0, id_a < id_b};
            OP_LUI:          alu_res = {id_b[15:0], 16'h0};
            OP_MFHI:         alu_res = hi;
            OP_MFLO:         alu_res = lo;
            default:         alu_res = 32'h0;
        endcase
    end

    assign is_mul    = (id_opt == OP_MULT) || (id_opt == OP_MULTU);
    assign is_div    = (id_opt == OP_DIV) || (id_opt == OP_DIVU);
    assign accept    = !mem_clear && !mem_stall && (state == ST_IDLE) && id_valid
                       && (id_exc_code == EC_NONE);
    assign start_mul = accept && is_mul;
    assign start_div = accept && is_div;

    // Division runs on magnitudes; signs are reapplied when the result is written.
    assign div_signed = (id_opt == OP_DIV);
    assign div_a_mag  = (div_signed && id_a[31]) ? -id_a : id_a;
    assign div_b_mag  = (div_signed && id_b[31]) ? -id_b : id_b;

    assign ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
    assign ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
    assign product = ext_a * ext_b;

    // One restoring step: trial[32] is the borrow, since rem < divisor keeps shifted < 2*divisor.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, op_b};
    assign ge      = !trial[32];
    assign rem_nx  = ge ? trial[31:0] : shifted[31:0];
    assign quo_nx  = {quo[30:0], ge};

    always_comb begin
        div_hi = neg_r ? -rem_nx : rem_nx;
        div_lo = neg_q ? -quo_nx : quo_nx;
        if (div_zero) begin
            div_hi = op_a;
            div_lo = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 5'd0;
            hi         <= 32'h0;
            lo         <= 32'h0;
            op_a       <= 32'h0;
            op_b       <= 32'h0;
            rem        <= 32'h0;
            quo        <= 32'h0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
        end else if (mem_clear) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_mul) begin
                        state      <= ST_MUL;
                        cnt        <= 5'(MUL_CYCLES - 1);
                        op_a       <= id_a;
                        op_b       <= id_b;
                        mul_signed <= (id_opt == OP_MULT);
                    end else if (start_div) begin
                        state    <= ST_DIV;
                        cnt      <= 5'd31;
                        op_a     <= id_a;
                        op_b     <= div_b_mag;
                        rem      <= 32'h0;
                        quo      <= div_a_mag;
                        neg_q    <= div_signed && (id_a[31] ^ id_b[31]);
                        neg_r    <= div_signed && id_a[31];
                        div_zero <= (id_b == 32'h0);
                    end else if (accept && id_opt == OP_MTHI) begin
                        hi <= id_a;
                    end else if (accept && id_opt == OP_MTLO) begin
                        lo <= id_a;
                    end
                end
                ST_MUL: begin
                    if (cnt == 5'd0) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == 5'd0) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_alu_result  <= 32'h0;
            ex_mem_addr    <= 32'h0;
            ex_mem_data    <= 32'h0;
            ex_exc_epc     <= 32'h0;
            ex_mem_opt     <= MEM_OPT_NONE;
            ex_wb_reg_addr <= '0;
            ex_exc_code    <= EC_NONE;
        end else if (mem_clear || !mem_stall) begin
            ex_alu_result  <= 32'h0;
            ex_mem_addr    <= 32'h0;
            ex_mem_data    <= 32'h0;
            ex_exc_epc     <= 32'h0;
            ex_mem_opt     <= MEM_OPT_NONE;
            ex_wb_reg_addr <= '0;
            ex_exc_code    <= EC_NONE;
            if (!mem_clear && !ex_stall && id_valid) begin
                if (id_exc_code != EC_NONE) begin
                    ex_exc_code <= id_exc_code;
                    ex_exc_epc  <= id_exc_epc;
                end else if (!is_mul && !is_div) begin
                    ex_alu_result  <= alu_res;
                    ex_mem_addr    <= sum;
                    ex_mem_data    <= id_mem_data;
                    ex_exc_epc     <= id_exc_epc;
                    ex_mem_opt     <= id_mem_opt;
                    ex_wb_reg_addr <= id_wb_reg_addr;
                    if ((id_opt == OP_ADD && add_ov) || (id_opt == OP_SUB && sub_ov)) begin
                        ex_exc_code    <= EC_OV;
                        ex_mem_opt     <= MEM_OPT_NONE;
                        ex_wb_reg_addr <= '0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex.sv
`default_nettype none
// tb_stage_ex -- vector table, hand sequences for multi-cycle corners, randomized run vs reference model
// Rev 1.0
module tb_stage_ex;

    localparam int MC = 3;
    localparam logic [4:0] OP_ADD = 5'd0,  OP_ADDU = 5'd1,  OP_SUB = 5'd2,  OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4,  OP_OR = 5'd5,    OP_XOR = 5'd6,  OP_NOR = 5'd7;
    localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL = 5'd9,   OP_SRA = 5'd10, OP_SLT = 5'd11;
    localparam logic [4:0] OP_SLTU = 5'd12, OP_LUI = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19;
    localparam logic [4:0] OP_MTHI = 5'd20, OP_MTLO = 5'd21;
    localparam logic [4:0] EC_OV = 5'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_opt;
    logic [31:0] id_a, id_b;
    logic [4:0]  id_shamt;
    logic [3:0]  id_mem_opt;
    logic [31:0] id_mem_data;
    logic [4:0]  id_wb_reg_addr;
    logic [4:0]  id_exc_code;
    logic [31:0] id_exc_epc;
    logic        mem_stall, mem_clear;
    logic        ex_stall;
    logic [31:0] ex_alu_result, ex_mem_addr, ex_mem_data, ex_exc_epc, ex_exc_badvaddr;
    logic [3:0]  ex_mem_opt;
    logic [4:0]  ex_wb_reg_addr;
    logic [4:0]  ex_exc_code;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stage_ex #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opt(id_opt), .id_a(id_a), .id_b(id_b),
        .id_shamt(id_shamt), .id_mem_opt(id_mem_opt), .id_mem_data(id_mem_data),
        .id_wb_reg_addr(id_wb_reg_addr), .id_exc_code(id_exc_code), .id_exc_epc(id_exc_epc),
        .mem_stall(mem_stall), .mem_clear(mem_clear), .ex_stall(ex_stall),
        .ex_alu_result(ex_alu_result), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .ex_exc_epc(ex_exc_epc), .ex_exc_badvaddr(ex_exc_badvaddr), .ex_mem_opt(ex_mem_opt),
        .ex_wb_reg_addr(ex_wb_reg_addr), .ex_exc_code(ex_exc_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] wb);
        id_valid = 1'b1; id_opt = op; id_a = a; id_b = b; id_shamt = sh; id_wb_reg_addr = wb;
        id_mem_opt = 4'h0; id_mem_data = 32'h0; id_exc_code = 5'h0; id_exc_epc = 32'h0;
    endtask

    task automatic idle();
        issue(OP_ADDU, 32'h0, 32'h0, 5'h0, 5'h0);
        id_valid = 1'b0;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (ex_stall && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic chk_zero_bundle(input string name);
        chk({name, "_res"}, ex_alu_result, 32'h0);
        chk({name, "_addr"}, ex_mem_addr, 32'h0);
        chk({name, "_data"}, ex_mem_data, 32'h0);
        chk({name, "_epc"}, ex_exc_epc, 32'h0);
        chk({name, "_misc"}, {14'h0, ex_exc_badvaddr == 32'h0, ex_stall, ex_mem_opt, ex_wb_reg_addr, ex_exc_code},
            {14'h0, 1'b1, 1'b0, 4'h0, 5'h0, 5'h0});
    endtask

    // Reference ALU in terms of the instruction semantics; returns {overflow, result}.
    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
        longint s;
        logic signed [31:0] sb;
        logic [31:0] r;
        logic ov;
        ov = 1'b0; r = 32'h0; sb = b; s = 0;
        case (op)
            OP_ADD, OP_ADDU: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                ov = (op == OP_ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            OP_SUB, OP_SUBU: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                ov = (op == OP_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SRA:  r = sb >>> sh;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_LUI:  r = {b[15:0], 16'h0};
            OP_MFHI: r = h;
            OP_MFLO: r = l;
            default: r = 32'h0;
        endcase
        return {ov, r};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [4:0]  exc;
        logic [4:0]  wb;
    } vec_t;

    vec_t tbl[15];

    // model state for the randomized phase
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_busy;
    logic [31:0] e_res, e_addr, e_data, e_epc;
    logic [3:0]  e_opt;
    logic [4:0]  e_wb, e_exc;

    initial begin
        int n;
        tbl[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, EC_OV, 5'd0};
        tbl[1]  = '{OP_ADDU, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 5'd0,  5'd9};
        tbl[2]  = '{OP_SUB,  32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, EC_OV, 5'd0};
        tbl[3]  = '{OP_SUBU, 32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF, 5'd0,  5'd9};
        tbl[4]  = '{OP_ADD,  32'h5,         32'hFFFF_FFFD, 5'd0,  32'h2,         5'd0,  5'd9};
        tbl[5]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 5'd0,  5'd9};
        tbl[6]  = '{OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0, 5'd0,  5'd9};
        tbl[7]  = '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 5'd0,  5'd9};
        tbl[8]  = '{OP_NOR,  32'h0,         32'hF000_0000, 5'd0,  32'h0FFF_FFFF, 5'd0,  5'd9};
        tbl[9]  = '{OP_SLL,  32'h0,         32'h1,         5'd31, 32'h8000_0000, 5'd0,  5'd9};
        tbl[10] = '{OP_SRL,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, 5'd0,  5'd9};
        tbl[11] = '{OP_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 5'd0,  5'd9};
        tbl[12] = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         5'd0,  5'd9};
        tbl[13] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         5'd0,  5'd9};
        tbl[14] = '{OP_LUI,  32'h0,         32'h0000_ABCD, 5'd0,  32'hABCD_0000, 5'd0,  5'd9};

        rst = 1'b0; mem_stall = 1'b0; mem_clear = 1'b0;
        idle();
        #12;
        chk_zero_bundle("reset");
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, 5'd9);
            tick();
            chk($sformatf("vec%0d_res", i), ex_alu_result, tbl[i].res);
            chk($sformatf("vec%0d_exc", i), {27'h0, ex_exc_code}, {27'h0, tbl[i].exc});
            chk($sformatf("vec%0d_wb", i), {27'h0, ex_wb_reg_addr}, {27'h0, tbl[i].wb});
            chk($sformatf("vec%0d_addr", i), ex_mem_addr, tbl[i].a + tbl[i].b);
        end

        // signed divide with MFLO/MFHI waiting behind it
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, 5'd0);
        tick();
        chk("div_issue_bubble_wb", {27'h0, ex_wb_reg_addr}, 32'h0);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd3);
        wait_stall(n);
        chk("div_stall_cycles", n, 32);
        chk("div_wait_bubble_wb", {27'h0, ex_wb_reg_addr}, 32'h0);
        tick();
        chk("div_lo", ex_alu_result, 32'hFFFF_FFFD);
        chk("div_lo_wb", {27'h0, ex_wb_reg_addr}, 32'd3);
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd3);
        tick();
        chk("div_hi", ex_alu_result, 32'hFFFF_FFFF);

        // unsigned divide by zero
        issue(OP_DIVU, 32'h7, 32'h0, 5'd0, 5'd0);
        tick();
        idle();
        wait_stall(n);
        chk("divu0_stall_cycles", n, 32);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd4);
        tick();
        chk("divu0_lo", ex_alu_result, 32'hFFFF_FFFF);
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd4);
        tick();
        chk("divu0_hi", ex_alu_result, 32'h7);

        // MULTU, MFHI issued immediately behind it
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
        tick();
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd2);
        wait_stall(n);
        chk("multu_stall_cycles", n, MC);
        tick();
        chk("multu_hi", ex_alu_result, 32'hFFFF_FFFE);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd2);
        tick();
        chk("multu_lo", ex_alu_result, 32'h0000_0001);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'h3, 5'd0, 5'd0);
        tick();
        idle();
        wait_stall(n);
        chk("mult_stall_cycles", n, MC);
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd2);
        tick();
        chk("mult_hi", ex_alu_result, 32'hFFFF_FFFF);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd2);
        tick();
        chk("mult_lo", ex_alu_result, 32'hFFFF_FFFA);

        // mem_stall holds the SLL result for 4 cycles
        issue(OP_SLL, 32'h0, 32'h1, 5'd4, 5'd5);
        tick();
        chk("sll_res", ex_alu_result, 32'h10);
        issue(OP_ADDU, 32'h2, 32'h3, 5'd0, 5'd6);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold%0d_res", i), ex_alu_result, 32'h10);
            chk($sformatf("hold%0d_wb", i), {27'h0, ex_wb_reg_addr}, 32'd5);
        end
        mem_stall = 1'b0;
        tick();
        chk("after_hold_res", ex_alu_result, 32'h5);
        chk("after_hold_wb", {27'h0, ex_wb_reg_addr}, 32'd6);

        // mem_clear at divide step 10 aborts without touching HI/LO
        issue(OP_MTHI, 32'h1111, 32'h0, 5'd0, 5'd0);
        tick();
        issue(OP_MTLO, 32'h2222, 32'h0, 5'd0, 5'd0);
        tick();
        issue(OP_DIV, 32'd100, 32'd7, 5'd0, 5'd0);
        tick();
        idle();
        for (int i = 0; i < 9; i++) tick();
        chk("clr_busy_before", {31'h0, ex_stall}, 32'h1);
        mem_clear = 1'b1;
        issue(OP_ADDU, 32'h1, 32'h1, 5'd0, 5'd7);
        tick();
        mem_clear = 1'b0;
        chk("clr_stall", {31'h0, ex_stall}, 32'h0);
        chk("clr_bubble", {23'h0, ex_mem_opt, ex_wb_reg_addr, ex_exc_code}, 32'h0);
        idle();
        for (int i = 0; i < 35; i++) tick();
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd1);
        tick();
        chk("clr_hi_kept", ex_alu_result, 32'h1111);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd1);
        tick();
        chk("clr_lo_kept", ex_alu_result, 32'h2222);

        // asynchronous reset in the middle of a divide
        issue(OP_DIV, 32'd50, 32'd3, 5'd0, 5'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk_zero_bundle("rst_mid_div");
        #2;
        rst = 1'b1;
        issue(OP_MFHI, 32'h0, 32'h0, 5'd0, 5'd1);
        tick();
        chk("rst_hi", ex_alu_result, 32'h0);
        issue(OP_MFLO, 32'h0, 32'h0, 5'd0, 5'd1);
        tick();
        chk("rst_lo", ex_alu_result, 32'h0);
        issue(OP_LUI, 32'h0, 32'h1234, 5'd0, 5'd7);
        id_mem_opt = 4'h2; id_mem_data = 32'hDEAD; id_exc_epc = 32'h400;
        tick();
        chk("lui_res", ex_alu_result, 32'h1234_0000);
        chk("lui_epc", ex_exc_epc, 32'h400);
        #2;
        rst = 1'b0;
        #1;
        chk_zero_bundle("rst_async");
        #2;
        rst = 1'b1;

        // randomized run against the reference model
        m_hi = 32'h0; m_lo = 32'h0; p_hi = 32'h0; p_lo = 32'h0; m_busy = 0;
        e_res = 32'h0; e_addr = 32'h0; e_data = 32'h0; e_epc = 32'h0;
        e_opt = 4'h0; e_wb = 5'h0; e_exc = 5'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [4:0] op;
            logic [32:0] r;
            bit pre_busy;
            int r5;
            if ($urandom_range(0, 15) == 0) op = 5'(OP_MULT + $urandom_range(0, 3));
            else begin
                r5 = $urandom_range(0, 17);
                op = (r5 < 14) ? 5'(r5) : 5'(r5 + 4);
            end
            id_valid       = ($urandom_range(0, 9) != 0);
            id_opt         = op;
            id_a           = rnd_val();
            id_b           = rnd_val();
            id_shamt       = 5'($urandom);
            id_mem_opt     = 4'($urandom);
            id_mem_data    = $urandom;
            id_wb_reg_addr = 5'($urandom);
            id_exc_code    = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
            id_exc_epc     = $urandom;
            mem_stall      = ($urandom_range(0, 9) == 0);
            mem_clear      = ($urandom_range(0, 39) == 0);

            pre_busy = (m_busy > 0);
            if (mem_clear || !mem_stall) begin
                e_res = 32'h0; e_addr = 32'h0; e_data = 32'h0; e_epc = 32'h0;
                e_opt = 4'h0; e_wb = 5'h0; e_exc = 5'h0;
                if (!mem_clear && !pre_busy && id_valid) begin
                    if (id_exc_code != 5'h0) begin
                        e_exc = id_exc_code;
                        e_epc = id_exc_epc;
                    end else if (op == OP_MULT) begin
                        {p_hi, p_lo} = longint'($signed(id_a)) * longint'($signed(id_b));
                        m_busy = MC;
                    end else if (op == OP_MULTU) begin
                        {p_hi, p_lo} = {32'h0, id_a} * {32'h0, id_b};
                        m_busy = MC;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
                        if (id_b == 32'h0) begin
                            p_lo = 32'hFFFF_FFFF; p_hi = id_a;
                        end else if (op == OP_DIV && id_a == 32'h8000_0000 && id_b == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = 32'h0;
                        end else if (op == OP_DIV) begin
                            p_lo = $signed(id_a) / $signed(id_b);
                            p_hi = $signed(id_a) % $signed(id_b);
                        end else begin
                            p_lo = id_a / id_b;
                            p_hi = id_a % id_b;
                        end
                        m_busy = 32;
                    end else begin
                        r = ref_alu(op, id_a, id_b, id_shamt, m_hi, m_lo);
                        e_res = r[31:0]; e_addr = id_a + id_b; e_data = id_mem_data;
                        e_epc = id_exc_epc; e_opt = id_mem_opt; e_wb = id_wb_reg_addr;
                        if (r[32]) begin
                            e_exc = EC_OV; e_opt = 4'h0; e_wb = 5'h0;
                        end
                        if (op == OP_MTHI) m_hi = id_a;
                        if (op == OP_MTLO) m_lo = id_a;
                    end
                end
            end
            if (pre_busy) begin
                if (mem_clear) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_hi = p_hi; m_lo = p_lo;
                    end
                end
            end

            tick();
            chk("rnd_res", ex_alu_result, e_res);
            chk("rnd_addr", ex_mem_addr, e_addr);
            chk("rnd_data", ex_mem_data, e_data);
            chk("rnd_epc", ex_exc_epc, e_epc);
            chk("rnd_ctl", {16'h0, ex_stall, ex_mem_opt, ex_wb_reg_addr, ex_exc_code, 1'b0},
                {16'h0, m_busy > 0, e_opt, e_wb, e_exc, 1'b0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
